waitstate_memory_controller: RTL and testbench

// - Parametrised CPU-to-on-chip-RAM controller with real ReadOK/WriteOK handshakes.
// - Adds configurable read latency, write wait states, byte enables and out-of-range bus-error reporting.
// - Sits between the core's data port, with the CpuDataInterface fields flattened to ports, and a synchronous single-port RAM.

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/mem_latency_counter.sv | 37 +++
 rtl/waitstate_memory_controller.sv | 161 ++++++++++++++++
 tb/tb_waitstate_memory_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the wait-state memory controller.
//   mem_state_t : controller FSM states
//   CNT_WIDTH   : width of the latency / wait-state down-counter
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } mem_state_t;

    localparam int CNT_WIDTH = 3;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter used to time both the read latency and the write
// wait states of the memory controller.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : load load_value on the next rising edge (wins over tick)
//   load_value  : value to load
//   tick        : decrement by one on the next rising edge (saturates at 0)
//   zero, one   : count is currently 0 / currently 1
module mem_latency_counter
    import mem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 tick,
    output logic                 zero,
    output logic                 one
);

    logic [CNT_WIDTH-1:0] count;

    // Load has priority over tick; the counter never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign zero = (count == '0);
    assign one  = (count == CNT_WIDTH'(1));

endmodule

// File: rtl/waitstate_memory_controller.sv
// CPU-to-on-chip-RAM controller with ReadOK/WriteOK handshakes, a
// configurable read latency, write wait states, byte enables and
// out-of-range bus-error reporting.
// Ports:
//   CoreClock, CoreReset_n : clock, asynchronous active-low reset
//   AddressBus             : CPU byte address (word index [ADDR_WIDTH+1:2])
//   DataWriteBus, ByteEnable, WriteAssert, ReadAssert : CPU request
//   DataReadBus            : registered read data
//   ReadOK, WriteOK        : one-cycle completion pulses
//   BusError               : pulses with the OK of an out-of-range access
//   MemAddress, MemWriteData, MemByteEnable, MemWriteEnable : RAM side
//   MemReadData            : RAM read data
module waitstate_memory_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_WAIT   = 0
) (
    input  logic                    CoreClock,
    input  logic                    CoreReset_n,
    input  logic [31:0]             AddressBus,
    input  logic [DATA_WIDTH-1:0]   DataWriteBus,
    input  logic [DATA_WIDTH/8-1:0] ByteEnable,
    input  logic                    WriteAssert,
    input  logic                    ReadAssert,
    output logic [DATA_WIDTH-1:0]   DataReadBus,
    output logic                    ReadOK,
    output logic                    WriteOK,
    output logic                    BusError,
    output logic [ADDR_WIDTH-1:0]   MemAddress,
    output logic [DATA_WIDTH-1:0]   MemWriteData,
    output logic [DATA_WIDTH/8-1:0] MemByteEnable,
    output logic                    MemWriteEnable,
    input  logic [DATA_WIDTH-1:0]   MemReadData
);

    mem_state_t           state;
    mem_state_t           state_next;
    logic                 request;
    logic                 out_of_range;
    logic                 txn_write;
    logic                 txn_err;
    logic                 capture;
    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_load_value;
    logic                 cnt_tick;
    logic                 cnt_zero;
    logic                 cnt_one;
    logic                 unused_addr_lsbs;

    assign request          = WriteAssert || ReadAssert;
    assign out_of_range     = |AddressBus[31:ADDR_WIDTH+2];
    assign unused_addr_lsbs = ^AddressBus[1:0];

    mem_latency_counter u_counter (
        .clk        (CoreClock),
        .rst_n      (CoreReset_n),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .tick       (cnt_tick),
        .zero       (cnt_zero),
        .one        (cnt_one)
    );

    always_ff @(posedge CoreClock or negedge CoreReset_n) begin
        if (!CoreReset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The write strobe cycle is spent in WR_WAIT with the
    // counter held, so WRITE_WAIT (up to 7) fits the 3-bit counter and the
    // wait cycles only start counting after the strobe.
    always_comb begin
        state_next     = state;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_tick       = 1'b0;
        capture        = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    cnt_load = 1'b1;
                    if (out_of_range) begin
                        state_next = DONE;
                    end else if (WriteAssert) begin
                        state_next     = WR_WAIT;
                        cnt_load_value = CNT_WIDTH'(WRITE_WAIT);
                    end else begin
                        state_next     = RD_WAIT;
                        cnt_load_value = CNT_WIDTH'(READ_LATENCY);
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_one) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_tick = 1'b1;
                end
            end
            WR_WAIT: begin
                if (MemWriteEnable) begin
                    if (cnt_zero) begin
                        state_next = DONE;
                    end
                end else if (cnt_one) begin
                    state_next = DONE;
                end else begin
                    cnt_tick = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch and RAM-side registers. An out-of-range read clears the
    // read data so the CPU never sees stale data alongside a bus error.
    always_ff @(posedge CoreClock or negedge CoreReset_n) begin
        if (!CoreReset_n) begin
            txn_write      <= 1'b0;
            txn_err        <= 1'b0;
            MemAddress     <= '0;
            MemWriteData   <= '0;
            MemByteEnable  <= '0;
            MemWriteEnable <= 1'b0;
            DataReadBus    <= '0;
        end else begin
            MemWriteEnable <= 1'b0;
            if ((state == IDLE) && request) begin
                txn_write      <= WriteAssert;
                txn_err        <= out_of_range;
                MemAddress     <= AddressBus[ADDR_WIDTH+1:2];
                MemWriteData   <= DataWriteBus;
                MemByteEnable  <= WriteAssert ? ByteEnable : '0;
                MemWriteEnable <= WriteAssert && !out_of_range;
                if (!WriteAssert && out_of_range) begin
                    DataReadBus <= '0;
                end
            end
            if (capture) begin
                DataReadBus <= MemReadData;
            end
        end
    end

    assign ReadOK   = (state == DONE) && !txn_write;
    assign WriteOK  = (state == DONE) && txn_write;
    assign BusError = (state == DONE) && txn_err;

endmodule

// File: tb/tb_waitstate_memory_controller.sv
// Directed self-checking bench for waitstate_memory_controller with
// READ_LATENCY=2 and WRITE_WAIT=2 against a small byte-lane RAM model.
module tb_waitstate_memory_controller;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int WW = 2;

    logic          CoreClock;
    logic          CoreReset_n;
    logic [31:0]   AddressBus;
    logic [DW-1:0] DataWriteBus;
    logic [3:0]    ByteEnable;
    logic          WriteAssert;
    logic          ReadAssert;
    logic [DW-1:0] DataReadBus;
    logic          ReadOK;
    logic          WriteOK;
    logic          BusError;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemWriteData;
    logic [3:0]    MemByteEnable;
    logic          MemWriteEnable;
    logic [DW-1:0] MemReadData;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    waitstate_memory_controller #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .WRITE_WAIT   (WW)
    ) dut (
        .CoreClock      (CoreClock),
        .CoreReset_n    (CoreReset_n),
        .AddressBus     (AddressBus),
        .DataWriteBus   (DataWriteBus),
        .ByteEnable     (ByteEnable),
        .WriteAssert    (WriteAssert),
        .ReadAssert     (ReadAssert),
        .DataReadBus    (DataReadBus),
        .ReadOK         (ReadOK),
        .WriteOK        (WriteOK),
        .BusError       (BusError),
        .MemAddress     (MemAddress),
        .MemWriteData   (MemWriteData),
        .MemByteEnable  (MemByteEnable),
        .MemWriteEnable (MemWriteEnable),
        .MemReadData    (MemReadData)
    );

    initial CoreClock = 1'b0;
    always #5 CoreClock = ~CoreClock;

    // RAM model: one registered read stage, so data for an address presented
    // after edge E is valid after E+1 and stable at the capture edge E+2.
    always @(posedge CoreClock) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (MemWriteEnable) begin
            for (int b = 0; b < 4; b++) begin
                if (MemByteEnable[b]) mem[MemAddress][8*b +: 8] <= MemWriteData[8*b +: 8];
            end
        end
        MemReadData <= mem[MemAddress];
    end

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_en   = 1'b1;
        @(negedge CoreClock);
        pl_en   = 1'b0;
    endtask

    task automatic test_reset();
        CoreReset_n = 1'b0;
        @(negedge CoreClock);
        checks++; if (ReadOK !== 1'b0) begin errors++; $display("[TB] FAIL reset_readok: got %b expected 0", ReadOK); end
        checks++; if (WriteOK !== 1'b0) begin errors++; $display("[TB] FAIL reset_writeok: got %b expected 0", WriteOK); end
        checks++; if (BusError !== 1'b0) begin errors++; $display("[TB] FAIL reset_buserror: got %b expected 0", BusError); end
        checks++; if (MemWriteEnable !== 1'b0) begin errors++; $display("[TB] FAIL reset_memwe: got %b expected 0", MemWriteEnable); end
        checks++; if (DataReadBus !== '0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", DataReadBus); end
        checks++; if (MemAddress !== '0) begin errors++; $display("[TB] FAIL reset_memaddr: got %h expected 0", MemAddress); end
    endtask

    task automatic test_read_latency();
        int rok_cycle = 0;
        int rok_cnt = 0;
        int other_cnt = 0;
        logic berr_seen = 1'b0;
        logic [AW-1:0] addr_seen = '0;
        logic [DW-1:0] rdata = '0;
        AddressBus = 32'h14;
        ReadAssert = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CoreClock);
            if (c == 1) addr_seen = MemAddress;
            if (WriteOK || MemWriteEnable) other_cnt++;
            if (BusError) berr_seen = 1'b1;
            if (ReadOK) begin
                rok_cnt++;
                if (rok_cycle == 0) begin rok_cycle = c; rdata = DataReadBus; end
                ReadAssert = 1'b0;
            end
        end
        checks++; if (addr_seen !== 14'd5) begin errors++; $display("[TB] FAIL rd_memaddr: got %0d expected 5", addr_seen); end
        checks++; if (rok_cycle !== RL + 1) begin errors++; $display("[TB] FAIL rd_latency: readok cycle %0d expected %0d", rok_cycle, RL + 1); end
        checks++; if (rok_cnt !== 1) begin errors++; $display("[TB] FAIL rd_ok_count: got %0d expected 1", rok_cnt); end
        checks++; if (rdata !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL rd_data: got %h expected a5a50001", rdata); end
        checks++; if (berr_seen !== 1'b0) begin errors++; $display("[TB] FAIL rd_buserror: got %b expected 0", berr_seen); end
        checks++; if (other_cnt !== 0) begin errors++; $display("[TB] FAIL rd_no_write: got %0d write cycles expected 0", other_cnt); end
        checks++; if (DataReadBus !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL rd_data_hold: got %h expected a5a50001", DataReadBus); end
    endtask

    task automatic test_write_wait();
        int we_cycle = 0;
        int we_cnt = 0;
        int wok_cycle = 0;
        int wok_cnt = 0;
        int rok_cnt = 0;
        logic [AW-1:0] we_addr = '0;
        logic [3:0] we_be = '0;
        logic [DW-1:0] we_data = '0;
        AddressBus   = 32'h20;
        DataWriteBus = 32'h1234_5678;
        ByteEnable   = 4'b0011;
        WriteAssert  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CoreClock);
            if (ReadOK) rok_cnt++;
            if (MemWriteEnable) begin
                we_cnt++;
                if (we_cycle == 0) begin we_cycle = c; we_addr = MemAddress; we_be = MemByteEnable; we_data = MemWriteData; end
            end
            if (WriteOK) begin
                wok_cnt++;
                if (wok_cycle == 0) wok_cycle = c;
                WriteAssert = 1'b0;
            end
        end
        checks++; if (we_cycle !== 1) begin errors++; $display("[TB] FAIL wr_strobe_cycle: got %0d expected 1", we_cycle); end
        checks++; if (we_cnt !== 1) begin errors++; $display("[TB] FAIL wr_strobe_count: got %0d expected 1", we_cnt); end
        checks++; if (we_addr !== 14'd8) begin errors++; $display("[TB] FAIL wr_memaddr: got %0d expected 8", we_addr); end
        checks++; if (we_be !== 4'b0011) begin errors++; $display("[TB] FAIL wr_byteenable: got %b expected 0011", we_be); end
        checks++; if (we_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL wr_memdata: got %h expected 12345678", we_data); end
        checks++; if (wok_cycle !== WW + 2) begin errors++; $display("[TB] FAIL wr_latency: writeok cycle %0d expected %0d", wok_cycle, WW + 2); end
        checks++; if (wok_cnt !== 1) begin errors++; $display("[TB] FAIL wr_ok_count: got %0d expected 1", wok_cnt); end
        checks++; if (rok_cnt !== 0) begin errors++; $display("[TB] FAIL wr_no_readok: got %0d expected 0", rok_cnt); end
        checks++; if (mem[8] !== 32'hFFFF_5678) begin errors++; $display("[TB] FAIL wr_ram_lanes: got %h expected ffff5678", mem[8]); end
    endtask

    task automatic test_priority();
        int wok_cnt = 0;
        int rok_cnt = 0;
        AddressBus   = 32'h0;
        DataWriteBus = 32'hCAFE_F00D;
        ByteEnable   = 4'hF;
        WriteAssert  = 1'b1;
        ReadAssert   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CoreClock);
            if (ReadOK) rok_cnt++;
            if (WriteOK) begin
                wok_cnt++;
                WriteAssert = 1'b0;
                ReadAssert  = 1'b0;
            end
        end
        checks++; if (wok_cnt !== 1) begin errors++; $display("[TB] FAIL prio_writeok: got %0d expected 1", wok_cnt); end
        checks++; if (rok_cnt !== 0) begin errors++; $display("[TB] FAIL prio_readok: got %0d expected 0", rok_cnt); end
        checks++; if (mem[0] !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL prio_ram: got %h expected cafef00d", mem[0]); end
    endtask

    task automatic test_out_of_range();
        int rok_cycle = 0;
        int berr_cycle = 0;
        int wok_cycle = 0;
        int we_cnt = 0;
        logic [DW-1:0] rdata = 32'hFFFF_FFFF;
        AddressBus = 32'h0001_0000;
        ReadAssert = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CoreClock);
            if (MemWriteEnable) we_cnt++;
            if (BusError && berr_cycle == 0) berr_cycle = c;
            if (ReadOK) begin
                if (rok_cycle == 0) begin rok_cycle = c; rdata = DataReadBus; end
                ReadAssert = 1'b0;
            end
        end
        checks++; if (rok_cycle !== 1) begin errors++; $display("[TB] FAIL oor_rd_ok_cycle: got %0d expected 1", rok_cycle); end
        checks++; if (berr_cycle !== 1) begin errors++; $display("[TB] FAIL oor_rd_buserror_cycle: got %0d expected 1", berr_cycle); end
        checks++; if (rdata !== '0) begin errors++; $display("[TB] FAIL oor_rd_data: got %h expected 0", rdata); end
        berr_cycle = 0;
        AddressBus   = 32'h0002_0000;
        DataWriteBus = 32'h5555_AAAA;
        ByteEnable   = 4'hF;
        WriteAssert  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CoreClock);
            if (MemWriteEnable) we_cnt++;
            if (BusError && berr_cycle == 0) berr_cycle = c;
            if (WriteOK) begin
                if (wok_cycle == 0) wok_cycle = c;
                WriteAssert = 1'b0;
            end
        end
        checks++; if (wok_cycle !== 1) begin errors++; $display("[TB] FAIL oor_wr_ok_cycle: got %0d expected 1", wok_cycle); end
        checks++; if (berr_cycle !== 1) begin errors++; $display("[TB] FAIL oor_wr_buserror_cycle: got %0d expected 1", berr_cycle); end
        checks++; if (we_cnt !== 0) begin errors++; $display("[TB] FAIL oor_no_strobe: got %0d strobes expected 0", we_cnt); end
    endtask

    task automatic test_back_to_back();
        int first = 0;
        int second = 0;
        int rok_cnt = 0;
        logic [DW-1:0] d1 = '0;
        logic [DW-1:0] d2 = '0;
        AddressBus = 32'h0;
        ReadAssert = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge CoreClock);
            if (ReadOK) begin
                rok_cnt++;
                if (rok_cnt == 1) begin
                    first = c; d1 = DataReadBus;
                    AddressBus = 32'h4;
                end else if (rok_cnt == 2) begin
                    second = c; d2 = DataReadBus;
                    ReadAssert = 1'b0;
                end
            end
        end
        checks++; if (rok_cnt !== 2) begin errors++; $display("[TB] FAIL b2b_ok_count: got %0d expected 2", rok_cnt); end
        checks++; if (second - first !== RL + 2) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", second - first, RL + 2); end
        checks++; if (d1 !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL b2b_data0: got %h expected cafef00d", d1); end
        checks++; if (d2 !== 32'h1111_2222) begin errors++; $display("[TB] FAIL b2b_data1: got %h expected 11112222", d2); end
    endtask

    task automatic test_reset_mid_write();
        int wok_cnt = 0;
        int rok_cycle = 0;
        logic we_before = 1'b0;
        logic [DW-1:0] rdata = '0;
        AddressBus   = 32'h10;
        DataWriteBus = 32'hDEAD_BEEF;
        ByteEnable   = 4'hF;
        WriteAssert  = 1'b1;
        @(negedge CoreClock);
        we_before   = MemWriteEnable;
        CoreReset_n = 1'b0;
        WriteAssert = 1'b0;
        #1;
        checks++; if (we_before !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_strobe_seen: got %b expected 1", we_before); end
        checks++; if (MemWriteEnable !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_memwe: got %b expected 0", MemWriteEnable); end
        checks++; if (MemAddress !== '0) begin errors++; $display("[TB] FAIL rst_mid_memaddr: got %h expected 0", MemAddress); end
        checks++; if (DataReadBus !== '0) begin errors++; $display("[TB] FAIL rst_mid_rdata: got %h expected 0", DataReadBus); end
        @(negedge CoreClock);
        CoreReset_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CoreClock);
            if (WriteOK) wok_cnt++;
        end
        checks++; if (wok_cnt !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_writeok: got %0d expected 0", wok_cnt); end
        AddressBus = 32'h14;
        ReadAssert = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CoreClock);
            if (WriteOK) wok_cnt++;
            if (ReadOK) begin
                if (rok_cycle == 0) begin rok_cycle = c; rdata = DataReadBus; end
                ReadAssert = 1'b0;
            end
        end
        checks++; if (rok_cycle !== RL + 1) begin errors++; $display("[TB] FAIL rst_after_rd_cycle: got %0d expected %0d", rok_cycle, RL + 1); end
        checks++; if (rdata !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL rst_after_rd_data: got %h expected a5a50001", rdata); end
        checks++; if (wok_cnt !== 0) begin errors++; $display("[TB] FAIL rst_after_writeok: got %0d expected 0", wok_cnt); end
    endtask

    initial begin
        CoreReset_n  = 1'b0;
        AddressBus   = '0;
        DataWriteBus = '0;
        ByteEnable   = '0;
        WriteAssert  = 1'b0;
        ReadAssert   = 1'b0;
        pl_en        = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;
        repeat (2) @(negedge CoreClock);
        test_reset();
        preload(14'd5, 32'hA5A5_0001);
        preload(14'd8, 32'hFFFF_FFFF);
        preload(14'd1, 32'h1111_2222);
        CoreReset_n = 1'b1;
        @(negedge CoreClock);
        test_read_latency();
        test_write_wait();
        test_priority();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
